// File: rtl/simon_pkg.sv
// Shared types and encodings for the Simon game sequencing controller.
// Holds the controller state enum, datapath mode/select encodings and the
// state-to-control decode used to build the registered outputs.
package simon_pkg;

    // Controller states
    typedef enum logic [3:0] {
        StInit,
        StInput,
        StWrite,
        StPlayStep,
        StPlayWait,
        StRepeat,
        StRepeatStep,
        StDoneArm,
        StDoneStep,
        StDoneWait
    } state_e;

    // Datapath mode encodings (mode_leds)
    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_INPUT  = 3'b001;
    localparam logic [2:0] MODE_PLAY   = 3'b010;
    localparam logic [2:0] MODE_REPEAT = 3'b100;
    localparam logic [2:0] MODE_DONE   = 3'b111;

    // Read-address mux encodings (select)
    localparam logic [1:0] SEL_PLAY   = 2'b00;
    localparam logic [1:0] SEL_REPEAT = 2'b01;
    localparam logic [1:0] SEL_DONE   = 2'b10;

    // Bundle of per-cycle datapath controls
    typedef struct packed {
        logic [1:0] select;
        logic [2:0] mode_leds;
        logic       clrcount;
        logic       w_en;
        logic       game_over;
    } ctrl_t;

    // Control values held while reset is asserted (matches the INIT decode)
    localparam ctrl_t CTRL_RESET = '{
        select:    SEL_PLAY,
        mode_leds: MODE_HOLD,
        clrcount:  1'b1,
        w_en:      1'b0,
        game_over: 1'b0
    };

    // Moore decode: the controls each state presents to the datapath
    function automatic ctrl_t decode_state(input state_e st);
        ctrl_t c;
        c = '{
            select:    SEL_PLAY,
            mode_leds: MODE_HOLD,
            clrcount:  1'b0,
            w_en:      1'b0,
            game_over: 1'b0
        };
        unique case (st)
            StInit: begin
                c.clrcount = 1'b1;
            end
            StInput: begin
                c.mode_leds = MODE_INPUT;
            end
            StWrite: begin
                c.mode_leds = MODE_INPUT;
                c.w_en      = 1'b1;
            end
            StPlayStep: begin
                c.mode_leds = MODE_PLAY;
            end
            StPlayWait: begin
                c.mode_leds = MODE_HOLD;
            end
            StRepeat: begin
                c.select = SEL_REPEAT;
            end
            StRepeatStep: begin
                c.select    = SEL_REPEAT;
                c.mode_leds = MODE_REPEAT;
            end
            StDoneArm: begin
                // Repeat-step mode pointed at the done index clears it to zero
                c.select    = SEL_DONE;
                c.mode_leds = MODE_REPEAT;
                c.game_over = 1'b1;
            end
            StDoneStep: begin
                c.select    = SEL_DONE;
                c.mode_leds = MODE_DONE;
                c.game_over = 1'b1;
            end
            StDoneWait: begin
                c.select    = SEL_DONE;
                c.game_over = 1'b1;
            end
            default: begin
                c.clrcount = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/simon_button_sync.sv
// Enter-button conditioning: two-flop synchronizer into the clk domain followed
// by a registered rising-edge detector. Emits one single-cycle pulse per press,
// however long the button is held.
module simon_button_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse_out
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    // Synchronize, remember the previous level, and register the rising edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_out = pulse_q;

endmodule

// File: rtl/simon_control.sv
// Sequencing controller for the Simon game datapath.
// Accepts player entries, plays the stored pattern back at a paced cadence,
// checks the player's repeat one entry per press, and parks in a replay loop
// on a loss or when memory is full.
// Build option: SIMON_PLAY_TIMER_EN adds the dwell timer so each entry is shown
// for PLAY_TICKS cycles; without it each entry takes two cycles.
module simon_control
    import simon_pkg::*;
#(
    parameter int unsigned PLAY_TICKS = 8,
    parameter int unsigned MAX_ROUNDS = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enter,
    input  logic       is_legal,
    input  logic       play_gt_count,
    input  logic       repeat_eq_play,
    input  logic       input_eq_pattern,
    output logic [1:0] select,
    output logic [2:0] mode_leds,
    output logic       clrcount,
    output logic       w_en,
    output logic [5:0] round,
    output logic       game_over
);

    localparam logic [5:0] MaxRound = 6'(MAX_ROUNDS);

    state_e     state_q;
    state_e     state_d;
    logic [5:0] round_q;
    logic [5:0] round_d;
    ctrl_t      ctrl_q;
    logic       enter_pulse;
    logic       wait_done;

    simon_button_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (enter),
        .pulse_out (enter_pulse)
    );

`ifdef SIMON_PLAY_TIMER_EN
    localparam int unsigned  TimerW    = (PLAY_TICKS > 2) ? $clog2(PLAY_TICKS) : 1;
    localparam logic [TimerW-1:0] TimerLoad = TimerW'(PLAY_TICKS - 1);

    logic [TimerW-1:0] timer_q;
    logic [TimerW-1:0] timer_d;

    // Step states arm the timer; wait states count it down
    always_comb begin
        timer_d = timer_q;
        if (state_q inside {StPlayStep, StDoneStep}) begin
            timer_d = TimerLoad;
        end else if (state_q inside {StPlayWait, StDoneWait}) begin
            timer_d = timer_q - TimerW'(1);
        end
    end

    // Leave the wait state on the cycle the count reaches zero, so the step
    // cycle plus PLAY_TICKS-1 wait cycles give PLAY_TICKS per entry
    assign wait_done = (timer_q == TimerW'(1));
`else
    // Without the timer every wait state lasts a single cycle
    assign wait_done = 1'b1;

    logic unused_play_ticks;
    assign unused_play_ticks = (PLAY_TICKS >= 2);
`endif

    // Next-state and round-count logic
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        unique case (state_q)
            StInit: begin
                state_d = StInput;
            end
            StInput: begin
                // Illegal entries are ignored; a full memory ends the game
                if (enter_pulse && is_legal) begin
                    state_d = (round_q < MaxRound) ? StWrite : StDoneArm;
                end
            end
            StWrite: begin
                round_d = round_q + 6'd1;
                state_d = StPlayStep;
            end
            StPlayStep: begin
                state_d = StPlayWait;
            end
            StPlayWait: begin
                if (wait_done) begin
                    state_d = play_gt_count ? StRepeat : StPlayStep;
                end
            end
            StRepeat: begin
                if (enter_pulse) begin
                    state_d = input_eq_pattern ? StRepeatStep : StDoneArm;
                end
            end
            StRepeatStep: begin
                state_d = repeat_eq_play ? StInput : StRepeat;
            end
            StDoneArm: begin
                state_d = StDoneStep;
            end
            StDoneStep: begin
                state_d = StDoneWait;
            end
            StDoneWait: begin
                if (wait_done) begin
                    state_d = StDoneStep;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // State, round, timer and registered controls decoded from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StInit;
            round_q <= 6'd0;
            ctrl_q  <= CTRL_RESET;
`ifdef SIMON_PLAY_TIMER_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            ctrl_q  <= decode_state(state_d);
`ifdef SIMON_PLAY_TIMER_EN
            timer_q <= timer_d;
`endif
        end
    end

    assign select    = ctrl_q.select;
    assign mode_leds = ctrl_q.mode_leds;
    assign clrcount  = ctrl_q.clrcount;
    assign w_en      = ctrl_q.w_en;
    assign game_over = ctrl_q.game_over;
    assign round     = round_q;

endmodule

// File: tb/tb_simon_control.sv
// Directed bench for simon_control with MAX_ROUNDS=2 and PLAY_TICKS=8.
module tb_simon_control;

    localparam int unsigned PlayTicks = 8;
    localparam int unsigned MaxRounds = 2;
`ifdef SIMON_PLAY_TIMER_EN
    localparam int unsigned Cadence = PlayTicks;
`else
    localparam int unsigned Cadence = 2;
`endif

    // Expected {select, mode_leds, clrcount, w_en, game_over}
    localparam logic [7:0] O_INIT  = {2'b00, 3'b000, 1'b1, 1'b0, 1'b0};
    localparam logic [7:0] O_INPUT = {2'b00, 3'b001, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] O_WRITE = {2'b00, 3'b001, 1'b0, 1'b1, 1'b0};
    localparam logic [7:0] O_PSTEP = {2'b00, 3'b010, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] O_PWAIT = {2'b00, 3'b000, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] O_REP   = {2'b01, 3'b000, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] O_RSTEP = {2'b01, 3'b100, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] O_DSTEP = {2'b10, 3'b111, 1'b0, 1'b0, 1'b1};
    localparam logic [7:0] O_DWAIT = {2'b10, 3'b000, 1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enter = 1'b0;
    logic       is_legal = 1'b0;
    logic       play_gt_count = 1'b0;
    logic       repeat_eq_play = 1'b0;
    logic       input_eq_pattern = 1'b0;
    logic [1:0] select;
    logic [2:0] mode_leds;
    logic       clrcount;
    logic       w_en;
    logic [5:0] round;
    logic       game_over;
    logic [7:0] outs;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    int wen_cycles = 0;
    int p0;
    int w0;
    int bad;

    simon_control #(
        .PLAY_TICKS (PlayTicks),
        .MAX_ROUNDS (MaxRounds)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enter            (enter),
        .is_legal         (is_legal),
        .play_gt_count    (play_gt_count),
        .repeat_eq_play   (repeat_eq_play),
        .input_eq_pattern (input_eq_pattern),
        .select           (select),
        .mode_leds        (mode_leds),
        .clrcount         (clrcount),
        .w_en             (w_en),
        .round            (round),
        .game_over        (game_over)
    );

    assign outs = {select, mode_leds, clrcount, w_en, game_over};

    always #5 clk = ~clk;

    // Count pulses and write strobes mid-cycle
    always @(negedge clk) begin
        if (dut.enter_pulse === 1'b1) pulses++;
        if (w_en === 1'b1) wen_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise enter for three edges (pulse is high afterwards), then release
    task automatic press();
        enter = 1'b1;
        tick();
        tick();
        tick();
        enter = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held 5 cycles
        repeat (5) tick();
        chk("reset_outs", outs, O_INIT);
        chk("reset_round", round, 0);
        rst = 1'b1;
        #1;
        chk("release_clr", outs, O_INIT);
        tick();
        chk("init_to_input", outs, O_INPUT);
        tick();
        chk("input_stable", outs, O_INPUT);

        // Illegal press held 20 cycles, then made legal while still held
        is_legal = 1'b0;
        p0 = pulses;
        w0 = wen_cycles;
        bad = 0;
        enter = 1'b1;
        repeat (20) begin
            tick();
            if (outs !== O_INPUT) bad++;
        end
        chk("illegal_stays_input", bad, 0);
        chk("illegal_one_pulse", pulses - p0, 1);
        is_legal = 1'b1;
        repeat (5) tick();
        chk("held_no_write", wen_cycles - w0, 0);
        chk("held_input", outs, O_INPUT);
        enter = 1'b0;
        repeat (3) tick();
        chk("illegal_round", round, 0);

        // Legal press: WRITE then paced playback
        w0 = wen_cycles;
        press();
        chk("pulse_in_input", outs, O_INPUT);
        tick();
        chk("write", outs, O_WRITE);
        chk("write_round", round, 0);
        tick();
        chk("play_step", outs, O_PSTEP);
        chk("round_1", round, 1);
        chk("one_write", wen_cycles - w0, 1);
        for (int k = 1; k <= int'(Cadence); k++) begin
            tick();
            chk("play_cadence", outs, (k == int'(Cadence)) ? O_PSTEP : O_PWAIT);
        end
        play_gt_count = 1'b1;
        repeat (Cadence - 1) tick();
        chk("play_last_wait", outs, O_PWAIT);
        tick();
        chk("to_repeat", outs, O_REP);

        // Correct repeat of the last entry returns to INPUT
        input_eq_pattern = 1'b1;
        repeat_eq_play = 1'b1;
        press();
        chk("repeat_waiting", outs, O_REP);
        tick();
        chk("repeat_step", outs, O_RSTEP);
        tick();
        chk("repeat_to_input", outs, O_INPUT);

        // Second round
        repeat (2) tick();
        press();
        tick();
        chk("write_2", outs, O_WRITE);
        tick();
        chk("play_step_2", outs, O_PSTEP);
        chk("round_2", round, 2);
        repeat (Cadence) tick();
        chk("to_repeat_2", outs, O_REP);
        repeat_eq_play = 1'b0;
        press();
        tick();
        chk("repeat_step_2a", outs, O_RSTEP);
        tick();
        chk("repeat_more", outs, O_REP);
        repeat_eq_play = 1'b1;
        press();
        tick();
        chk("repeat_step_2b", outs, O_RSTEP);
        tick();
        chk("repeat_to_input_2", outs, O_INPUT);

        // Memory full: legal press goes to DONE_ARM without writing
        repeat (2) tick();
        w0 = wen_cycles;
        press();
        tick();
        chk("full_arm_mode", mode_leds, 3'b100);
        chk("full_arm_no_wen", w_en, 1'b0);
        tick();
        chk("full_done_step", outs, O_DSTEP);
        chk("full_round", round, 2);
        for (int k = 1; k <= int'(Cadence); k++) begin
            tick();
            chk("done_cadence", outs, (k == int'(Cadence)) ? O_DSTEP : O_DWAIT);
        end
        chk("full_no_write", wen_cycles - w0, 0);

        // Reset mid-DONE returns INIT values at once
        rst = 1'b0;
        #1;
        chk("rst_done_outs", outs, O_INIT);
        chk("rst_done_round", round, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_done_input", outs, O_INPUT);

        // Reset mid-playback
        repeat (2) tick();
        press();
        tick();
        chk("write_3", outs, O_WRITE);
        tick();
        chk("play_step_3", outs, O_PSTEP);
        tick();
        chk("play_wait_3", outs, O_PWAIT);
        rst = 1'b0;
        #1;
        chk("rst_play_outs", outs, O_INIT);
        chk("rst_play_round", round, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_play_input", outs, O_INPUT);

        // Loss: wrong repeat entry ends the game
        repeat (2) tick();
        press();
        tick();
        chk("write_4", outs, O_WRITE);
        tick();
        chk("round_4", round, 1);
        repeat (Cadence) tick();
        chk("to_repeat_4", outs, O_REP);
        input_eq_pattern = 1'b0;
        press();
        tick();
        chk("loss_arm_mode", mode_leds, 3'b100);
        tick();
        chk("loss_done_step", outs, O_DSTEP);
        for (int k = 1; k <= int'(Cadence); k++) begin
            tick();
            chk("loss_cadence", outs, (k == int'(Cadence)) ? O_DSTEP : O_DWAIT);
        end
        press();
        tick();
        chk("done_ignores_press", game_over, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
